instr_encoder_loader: RTL
=========================

# instr_encoder_loader

Sequential instruction encoder and program loader: the write-side counterpart of the control decoder. It accepts a stream of symbolic instructions (kind selector plus operand fields) over a valid/ready handshake, packs each into the 32-bit word format the decoder consumes, and writes the words into consecutive instruction-memory locations. It sits between the testbench or boot source and the instruction memory, and it runs only while the core is held off.

## Interface
- ADDR_W, 8: instruction-memory word-address width; DEPTH = 2**ADDR_W words.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin a new load session; sampled in IDLE and DONE only.
- in_valid  in  1  instruction fields valid.
- in_ready  out  1  loader accepts this cycle.
- in_kind  in  4  0 RTYPE, 1 SLL, 2 JMSUB, 3 LW, 4 SW, 5 BEQ, 6 ORI, 7 BLTZ, 8 JRS, 9 BALN, 10 END, 11–15 illegal.
- in_rs, in_rt, in_rd, in_shamt  in  5 each  register and shift fields.
- in_funct  in  6  function field, used only by RTYPE.
- in_imm  in  16  immediate / branch offset.
- in_target  in  26  jump target (BALN).
- mem_we  out  1  one-cycle write strobe to instruction memory.
- mem_addr  out  ADDR_W  word address of the write.
- mem_wdata  out  32  encoded instruction.
- busy  out  1  high in LOAD.
- done  out  1  high in DONE.
- err  out  1  sticky flag: an illegal kind was received this session.
- word_count  out  ADDR_W+1  number of words written this session.

## Operation
- States: IDLE → LOAD on start. LOAD → DONE on an accepted END, or on acceptance of the word that makes the count equal DEPTH. DONE → LOAD on start, which clears word_count and err. start is ignored in LOAD.
- in_ready = (state==LOAD) && (accepted count < DEPTH). A transfer occurs when in_valid && in_ready at a rising edge.
- Encoding of an accepted word:
  - R-format {000000, rs, rt, rd, shamt, funct}. RTYPE uses in_funct. SLL forces funct 000000 and rs 00000. JMSUB forces funct 100010.
  - I-format {op, rs, rt, imm}: LW op 100011, SW 101011, BEQ 000100, ORI 001101, BLTZ 000001 (rt forced 00000), JRS 010010.
  - J-format {011011, target} for BALN.
  - Unused inputs are don't-care; the encoded word depends only on fields used by that kind.
- END: consumed, no write, no count change, state → DONE.
- Illegal kind (11–15): consumed, no write, no count change, err set, state remains LOAD.
- Write address equals word_count at acceptance, starting at 0 each session. Addresses never wrap: at count DEPTH, in_ready drops and the state goes to DONE.

## Timing
- Reset values: state IDLE, in_ready 0, mem_we 0, mem_addr 0, mem_wdata 0, busy 0, done 0, err 0, word_count 0.
- Latency: word accepted at edge N → mem_we=1 with addr/data valid for exactly the cycle after edge N. word_count increments at edge N.
- Throughput is one word per cycle with no bubbles. mem_addr/mem_wdata hold their last value when mem_we=0.
- Accepting the last slot (count DEPTH-1 → DEPTH) moves the state to DONE at the same edge. The final mem_we pulse occurs in the first DONE cycle, with done=1.
- Accepted END: done=1 and busy=0 from the next cycle; mem_we stays 0.
- start is registered: in_ready rises one cycle after start is sampled.
- Reset mid-session: at the reset edge all outputs return to reset values and any pending write strobe is cancelled. Memory contents are untouched.
- in_valid while in_ready=0 is not consumed. The source holds the fields stable until the transfer.

## Test plan
- Reset, start, then LW rs=29 rt=8 imm=0x0004 → mem_we one cycle later, addr 0, data 0x8FA80004; word_count=1.
- Back-to-back ORI rs=0 rt=9 imm=0x00FF, then SLL rd=10 rt=9 shamt=2, then JMSUB rs=3 rt=4 rd=5 → consecutive writes to addr 0,1,2 with data 0x340900FF, 0x00095080, 0x00642822, no gaps.
- BEQ rs=1 rt=2 imm=0xFFFF, kind 13, BALN target 0x10, END → writes 0x1022FFFF @0 and 0x6C000010 @1; err=1; done=1; word_count=2.
- ADDR_W=2 with in_valid held high and 5 words offered → exactly 4 writes @0..3; in_ready low after the 4th acceptance; done on the cycle of the 4th mem_we; 5th word not consumed.
- Reset asserted the cycle after an acceptance → no mem_we that cycle; all outputs at reset values. A subsequent start writes again from addr 0.
- In DONE, assert start → word_count=0, err=0, busy=1. A new session overwrites from addr 0.

Source files
------------

// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader: packs symbolic instructions into 32-bit decoder words
// and writes them into consecutive instruction-memory locations, one per cycle.
module instr_encoder_loader #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_kind,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_shamt,
    input  logic [5:0]        in_funct,
    input  logic [15:0]       in_imm,
    input  logic [25:0]       in_target,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   word_count
);

    // Count at which memory is full, and the count of the last free slot.
    localparam logic [ADDR_W:0] FULL_C = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] LAST_C = {1'b0, {ADDR_W{1'b1}}};

    localparam logic [3:0] K_RTYPE = 4'd0;
    localparam logic [3:0] K_SLL   = 4'd1;
    localparam logic [3:0] K_JMSUB = 4'd2;
    localparam logic [3:0] K_LW    = 4'd3;
    localparam logic [3:0] K_SW    = 4'd4;
    localparam logic [3:0] K_BEQ   = 4'd5;
    localparam logic [3:0] K_ORI   = 4'd6;
    localparam logic [3:0] K_BLTZ  = 4'd7;
    localparam logic [3:0] K_JRS   = 4'd8;
    localparam logic [3:0] K_BALN  = 4'd9;
    localparam logic [3:0] K_END   = 4'd10;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              err_q, err_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;

    logic [31:0]       enc;
    logic              legal;
    logic              accept;

    // Pack the presented fields according to the instruction kind.
    always_comb begin
        enc   = 32'h0;
        legal = 1'b1;
        case (in_kind)
            K_RTYPE: enc = {6'b000000, in_rs, in_rt, in_rd, in_shamt, in_funct};
            K_SLL:   enc = {6'b000000, 5'b00000, in_rt, in_rd, in_shamt, 6'b000000};
            K_JMSUB: enc = {6'b000000, in_rs, in_rt, in_rd, in_shamt, 6'b100010};
            K_LW:    enc = {6'b100011, in_rs, in_rt, in_imm};
            K_SW:    enc = {6'b101011, in_rs, in_rt, in_imm};
            K_BEQ:   enc = {6'b000100, in_rs, in_rt, in_imm};
            K_ORI:   enc = {6'b001101, in_rs, in_rt, in_imm};
            K_BLTZ:  enc = {6'b000001, in_rs, 5'b00000, in_imm};
            K_JRS:   enc = {6'b010010, in_rs, in_rt, in_imm};
            K_BALN:  enc = {6'b011011, in_target};
            default: legal = 1'b0;
        endcase
    end

    assign in_ready = (state_q == S_LOAD) && (count_q < FULL_C);
    assign accept   = in_valid && in_ready;

    // Session control and write-strobe generation.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        err_d   = err_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_LOAD;
                    count_d = '0;
                    err_d   = 1'b0;
                end
            end
            S_LOAD: begin
                if (accept) begin
                    if (in_kind == K_END) begin
                        state_d = S_DONE;
                    end else if (!legal) begin
                        err_d = 1'b1;
                    end else begin
                        we_d    = 1'b1;
                        addr_d  = count_q[ADDR_W-1:0];
                        wdata_d = enc;
                        count_d = count_q + 1'b1;
                        // Filling the last slot ends the session; no wrap.
                        if (count_q == LAST_C) state_d = S_DONE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers; reset also cancels a pending strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            count_q <= '0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            err_q   <= err_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign mem_we     = we_q;
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign busy       = (state_q == S_LOAD);
    assign done       = (state_q == S_DONE);
    assign err        = err_q;
    assign word_count = count_q;

endmodule
